uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (5..8 data bits, optional parity, 1/2 stop) with ready/valid input
module uart_tx_cfg #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 9600,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 po_ready,
  output logic                 po_done,
  output logic                 tx
);

  // Frame-format legality is fixed at elaboration; nothing is checked at run time.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS=%0d outside 5..8", DATA_BITS);
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY=%0d must be 0, 1 or 2", PARITY);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (BAUD_CNT_MAX < 2 || BAUD_CNT_MAX > 65535) begin : g_bad_baud
    $error("uart_tx_cfg: BAUD_CNT_MAX=%0d outside 2..65535", BAUD_CNT_MAX);
  end

  // Terminal values of the bit-period counter and of the data / stop bit index.
  localparam logic [15:0] BAUD_LAST  = 16'(BAUD_CNT_MAX - 1);
  localparam logic [2:0]  DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit          HAS_PARITY = (PARITY != 0);
  localparam bit          ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            baud_cnt_q, baud_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  // The current bit has been on the line for its full period this cycle.
  assign baud_end = (baud_cnt_q == BAUD_LAST);

  // State and datapath registers; reset drives the line idle-high immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state, bit sequencing and handshake outputs for one frame.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    po_ready   = 1'b0;
    po_done    = 1'b0;

    // Outside IDLE the counter free-runs over one bit period and wraps on its terminal cycle.
    if (state_q != S_IDLE) begin
      baud_cnt_d = baud_end ? 16'd0 : baud_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        po_ready   = 1'b1;
        baud_cnt_d = 16'd0;
        bit_idx_d  = 3'd0;
        if (pi_flag) begin
          // Data and its parity are captured together so later pi_data changes cannot leak in.
          shift_d  = pi_data;
          parity_d = ODD_PARITY ? ~^pi_data : ^pi_data;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = 3'd0;
            state_d   = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            // LSB-first: the bit on the line is always shift_q[0].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_idx_q == STOP_LAST) begin
            po_done   = 1'b1;
            bit_idx_d = 3'd0;
            state_d   = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, registered so tx is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg over five frame formats
module tb_uart_tx_cfg;

  typedef struct packed {
    logic [15:0] bits;
    logic [7:0]  n;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [4:0] settled;

  task automatic chk(string name, int inst, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", name, inst, act, req, $time);
    end
  endtask

  // Instance table: 0=8N1, 1=8E1, 2=8O1, 3=7N2 (all 10 clocks/bit), 4=8N1 at 50 MHz / 9600.
  function automatic int cf_of(int i);   return (i == 4) ? 50_000_000 : 1_000_000; endfunction
  function automatic int bps_of(int i);  return (i == 4) ? 9600 : 100_000; endfunction
  function automatic int db_of(int i);   return (i == 3) ? 7 : 8; endfunction
  function automatic int par_of(int i);  return (i == 1) ? 2 : (i == 2) ? 1 : 0; endfunction
  function automatic int sb_of(int i);   return (i == 3) ? 2 : 1; endfunction
  function automatic int baud_of(int i); return (i == 4) ? 5208 : 10; endfunction
  function automatic int nfr_of(int i);  return (i == 0) ? 12 : (i == 4) ? 1 : 6; endfunction
  function automatic int abort_of(int i); return (i == 0) ? 10 : -1; endfunction

  function automatic int fixed_of(int i, int k);
    if (i == 0 && k == 1)  return 8'h55;
    if (i == 0 && k == 2)  return 8'hAA;
    if (i == 0 && k == 11) return 8'h0F;
    if (i == 3 && k == 0)  return 7'h41;
    if (k == 0)            return 8'hA5;
    return -1;
  endfunction

  function automatic int gap_of(int i, int k);
    if (i == 0 && k == 2) return 0;
    return -1;
  endfunction

  // Reference frame: start, data LSB first, parity making the ones-count even/odd, stop bits.
  function automatic exp_t build(int d, int db, int par, int sb, int acc);
    exp_t e;
    int   n    = 0;
    int   ones = 0;
    e.bits = '0;
    e.bits[n] = 1'b0; n++;
    for (int b = 0; b < db; b++) begin
      e.bits[n] = 1'((d >> b) & 1);
      ones += (d >> b) & 1;
      n++;
    end
    if (par == 2) begin e.bits[n] = 1'(ones % 2);       n++; end
    if (par == 1) begin e.bits[n] = 1'((ones + 1) % 2); n++; end
    for (int s = 0; s < sb; s++) begin e.bits[n] = 1'b1; n++; end
    e.n   = 8'(n);
    e.acc = 32'(acc);
    return e;
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : g_inst
    localparam int DB = db_of(gi);
    localparam int B  = baud_of(gi);

    logic          rst_n;
    logic          flag;
    logic          ready;
    logic          done;
    logic          tx;
    logic [DB-1:0] data;
    exp_t          q[$];
    int            pend = 0;
    bit            drv_done = 1'b0;

    uart_tx_cfg #(
      .CLK_FREQ (cf_of(gi)),
      .UART_BPS (bps_of(gi)),
      .DATA_BITS(DB),
      .PARITY   (par_of(gi)),
      .STOP_BITS(sb_of(gi))
    ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .pi_data  (data),
      .pi_flag  (flag),
      .po_ready (ready),
      .po_done  (done),
      .tx       (tx)
    );

    assign settled[gi] = drv_done && (pend == 0) && ready;

    // Driver: issues frames, pushes the expected frame on accept, injects ignored requests while busy.
    initial begin
      int d;
      int g;
      int lim;
      int acc;
      rst_n = 1'b0;
      flag  = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_tx", gi, tx, 1);
      chk("reset_ready", gi, ready, 1);
      chk("reset_done", gi, done, 0);
      rst_n = 1'b1;
      g = 0;
      for (int k = 0; k < nfr_of(gi); k++) begin
        d = fixed_of(gi, k);
        if (d < 0) d = int'($urandom_range(0, (1 << DB) - 1));
        lim = 0;
        while (!ready && lim < 60000) begin
          flag = (g == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          data = DB'($urandom);
          @(negedge clk);
          lim++;
        end
        if (!ready) begin
          chk("ready_timeout", gi, 0, 1);
          break;
        end
        repeat (g) begin
          flag = 1'b0;
          @(negedge clk);
        end
        flag = 1'b1;
        data = DB'(d);
        acc  = cyc;
        q.push_back(build(d, DB, par_of(gi), sb_of(gi), acc));
        pend++;
        @(negedge clk);
        g = gap_of(gi, k + 1);
        if (g < 0) g = int'($urandom_range(0, 3));
        if (k == abort_of(gi)) begin
          while (cyc < acc + 45) begin
            flag = 1'($urandom_range(0, 1));
            data = DB'($urandom);
            @(negedge clk);
          end
          #2 rst_n = 1'b0;
          #1;
          chk("abort_tx", gi, tx, 1);
          chk("abort_ready", gi, ready, 1);
          flag = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      flag = 1'b0;
      drv_done = 1'b1;
    end

    // Monitor: on each start bit, pop the expected frame and compare the line cycle by cycle.
    initial begin
      exp_t e;
      int   wb;
      int   dbad;
      int   rb;
      int   lim;
      int   nb;
      bit   ab;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_frame", gi, 1, 0);
            lim = 0;
            while (!ready && lim < 60000) begin
              @(negedge clk);
              lim++;
            end
          end else begin
            e  = q.pop_front();
            nb = int'(e.n) * B;
            chk("start_cycle", gi, cyc, e.acc + 1);
            wb = 0; dbad = 0; rb = 0; ab = 1'b0;
            for (int k = 0; k < nb; k++) begin
              if (k > 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                ab = 1'b1;
                break;
              end
              if (tx !== e.bits[k / B]) wb++;
              if (done !== (k == nb - 1)) dbad++;
              if (ready !== 1'b0) rb++;
            end
            chk("frame_wave_bad_cycles", gi, wb, 0);
            chk("done_bad_cycles", gi, dbad, 0);
            chk("ready_during_frame", gi, rb, 0);
            if (!ab) begin
              @(negedge clk);
              chk("ready_after_frame", gi, ready, 1);
              chk("tx_after_frame", gi, tx, 1);
              chk("done_after_frame", gi, done, 0);
            end
            pend--;
          end
        end
      end
    end
  end

  // Wait for every instance to drain, linger to catch spurious frames, then report.
  initial begin
    int lim = 0;
    @(negedge clk);
    while (settled !== 5'h1f && lim < 95000) begin
      @(negedge clk);
      lim++;
    end
    chk("all_frames_settled", -1, settled, 5'h1f);
    repeat (30) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
